// File: rtl/asrv32_dmem_responder.sv
// ---------------------------------------------------------------------------
// asrv32_dmem_responder
//
// Data-memory responder at the far end of the core's memory-access stage.
// It accepts one load or store at a time, waits a programmable number of
// cycles, then performs a byte-masked write or a full-word read on an
// internal word array and returns a one-cycle acknowledge. Lane extraction
// and sign/zero extension are left to the core: a load always returns the
// whole 32-bit word.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words in the array (power of two)
//   WAIT_STATES  extra cycles between acceptance and access (0..15)
//   BASE_ADDR    byte address of word 0 (aligned to 4*DEPTH_WORDS)
//
// Ports:
//   i_clk      clock, all state changes on the rising edge
//   i_rst_n    asynchronous active-low reset
//   i_req      request valid, sampled only while o_stall=0
//   i_wr_en    1 = store, 0 = load
//   i_addr     byte address, bits [1:0] ignored
//   i_wr_data  lane-aligned store data
//   i_wr_mask  byte enables {b3,b2,b1,b0} for stores
//   o_rd_data  read word, valid while o_ack=1
//   o_ack      one-cycle completion pulse
//   o_err      out-of-range flag, valid while o_ack=1
//   o_stall    busy, no new request is accepted
// ---------------------------------------------------------------------------
module asrv32_dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_wr_mask,
  output logic [31:0] o_rd_data,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_stall
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);
  // Range limit is kept at 33 bits so a window ending at the top of the
  // 32-bit address space does not wrap around to zero.
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + SPAN;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        in_range;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  // Decode works on the latched address so input changes while busy are
  // invisible to the access.
  assign in_range = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);
  assign idx      = addr[AW+1:2];
  assign o_stall  = (state != IDLE);

  // Control FSM with registered ack/err/read data. Ack and err default low
  // every edge so they form a single-cycle pulse after the ACCESS edge; the
  // ack cycle is already IDLE, allowing back-to-back acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      count     <= '0;
      addr      <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      wr_mask   <= '0;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_rd_data <= '0;
    end else begin
      o_ack <= 1'b0;
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            addr    <= i_addr;
            wr_en   <= i_wr_en;
            wr_data <= i_wr_data;
            wr_mask <= i_wr_mask;
            count   <= WS;
            state   <= (WS != 4'd0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          o_ack <= 1'b1;
          o_err <= ~in_range;
          if (!wr_en) begin
            o_rd_data <= in_range ? mem[idx] : 32'h0;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Array write port. Not reset so stored data survives a reset; a reset
  // during WAIT/ACCESS forces the FSM to IDLE before this edge can commit.
  always_ff @(posedge i_clk) begin
    if (state == ACCESS && wr_en && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_asrv32_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_asrv32_dmem_responder
//
// Self-checking bench. One instance uses one wait state for the directed
// store/load, lane merge, range and reset cases; a second instance with no
// wait states exercises back-to-back requests. A shadow memory predicts
// every ack and pushes it onto a scoreboard queue that is popped on ack.
// ---------------------------------------------------------------------------
module tb_asrv32_dmem_responder;

  localparam int WS1 = 1;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        req, wr_en;
  logic [31:0] addr, wr_data;
  logic [3:0]  wr_mask;
  logic [31:0] rd_data;
  logic        ack, err, stall;

  logic        req0, wr_en0;
  logic [31:0] addr0, wr_data0;
  logic [3:0]  wr_mask0;
  logic [31:0] rd_data0;
  logic        ack0, err0, stall0;

  exp_t        sb[$];
  logic [31:0] model [logic [31:0]];
  logic [31:0] last_rd;
  logic [31:0] last_rd0;
  int          checks = 0;
  int          errors = 0;

  asrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS1), .BASE_ADDR(32'h0000_1000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wr_en(wr_en), .i_addr(addr),
    .i_wr_data(wr_data), .i_wr_mask(wr_mask), .o_rd_data(rd_data), .o_ack(ack),
    .o_err(err), .o_stall(stall)
  );

  asrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_wr_en(wr_en0), .i_addr(addr0),
    .i_wr_data(wr_data0), .i_wr_mask(wr_mask0), .o_rd_data(rd_data0), .o_ack(ack0),
    .o_err(err0), .o_stall(stall0)
  );

  // Window is 0x1000..0x1FFF for 1024 words at base 0x1000.
  function automatic bit inRange(input logic [31:0] a);
    return (a >= 32'h0000_1000) && (a < 32'h0000_2000);
  endfunction

  // Shadow-memory prediction of one request; pushes the expected ack.
  task automatic predict(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, inout logic [31:0] last);
    exp_t        e;
    logic [31:0] key;
    logic [31:0] cur;
    key = {a[31:2], 2'b00};
    cur = model.exists(key) ? model[key] : 32'h0;
    if (!inRange(a)) begin
      e.err = 1'b1;
      if (!w) last = 32'h0;
    end else begin
      e.err = 1'b0;
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
        end
        model[key] = cur;
      end else begin
        last = cur;
      end
    end
    e.rd = last;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One request on the wait-state instance: drive for one cycle, scramble
  // the inputs while busy, then wait (bounded) for the ack and compare.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] m);
    int   cycles;
    exp_t e;
    predict(w, a, d, m, last_rd);
    req = 1'b1; wr_en = w; addr = a; wr_data = d; wr_mask = m;
    @(negedge clk);
    req = 1'b0; wr_en = ~w; addr = $urandom; wr_data = $urandom; wr_mask = 4'($urandom);
    cycles = 1;
    while (ack !== 1'b1 && cycles < 20) begin
      checkOutput("stall_busy", {31'b0, stall}, 32'd1);
      @(negedge clk);
      cycles++;
    end
    checkOutput("latency", cycles, 32'(2 + WS1));
    e = sb.pop_front();
    if (ack === 1'b1) begin
      checkOutput("rd_data", rd_data, e.rd);
      checkOutput("err", {31'b0, err}, {31'b0, e.err});
      checkOutput("stall_at_ack", {31'b0, stall}, 32'd0);
    end
    @(negedge clk);
    checkOutput("ack_drop", {31'b0, ack}, 32'd0);
  endtask

  initial begin
    exp_t e;
    req = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; wr_mask = '0;
    req0 = 1'b0; wr_en0 = 1'b0; addr0 = '0; wr_data0 = '0; wr_mask0 = '0;
    last_rd = '0; last_rd0 = '0;

    // Reset held with a pending request, then idle after release.
    rst_n = 1'b0;
    req = 1'b1; wr_en = 1'b1; addr = 32'h1000; wr_data = 32'hFFFF_FFFF; wr_mask = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", {31'b0, ack}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1; req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_no_ack", {31'b0, ack}, 32'd0);
    end

    // Full-word store and load.
    applyStimulus(1'b1, 32'h1004, 32'hDEAD_BEEF, 4'b1111);
    applyStimulus(1'b0, 32'h1004, 32'h0, 4'b0000);

    // Byte-lane merge, including an empty mask.
    applyStimulus(1'b1, 32'h1008, 32'h1122_3344, 4'b1111);
    applyStimulus(1'b1, 32'h1008, 32'h0000_AB00, 4'b0010);
    applyStimulus(1'b0, 32'h1008, 32'h0, 4'b0000);
    applyStimulus(1'b1, 32'h1008, 32'hCDEF_0000, 4'b1100);
    applyStimulus(1'b0, 32'h1008, 32'h0, 4'b0000);
    applyStimulus(1'b1, 32'h1008, 32'h9999_9999, 4'b0000);
    applyStimulus(1'b0, 32'h100B, 32'h0, 4'b0000);

    // Out-of-range accesses, including the top of the address space.
    applyStimulus(1'b0, 32'h0FFC, 32'h0, 4'b0000);
    applyStimulus(1'b0, 32'h2000, 32'h0, 4'b0000);
    applyStimulus(1'b0, 32'hFFFF_FFFC, 32'h0, 4'b0000);
    applyStimulus(1'b0, 32'h1004, 32'h0, 4'b0000);
    applyStimulus(1'b1, 32'h0FFC, 32'hFFFF_FFFF, 4'b1111);
    applyStimulus(1'b0, 32'h1004, 32'h0, 4'b0000);
    applyStimulus(1'b0, 32'h1008, 32'h0, 4'b0000);
    applyStimulus(1'b1, 32'h1FFC, 32'h7777_8888, 4'b1111);
    applyStimulus(1'b0, 32'h1FFC, 32'h0, 4'b0000);

    // Back-to-back on the zero-wait instance with the request held high.
    for (int k = 0; k < 4; k++) begin
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      w = (k % 2 == 0);
      a = (k < 2) ? 32'h1100 : 32'h1104;
      d = (k < 2) ? 32'hA5A5_0001 : 32'h0BAD_F00D;
      predict(w, a, d, 4'hF, last_rd0);
      req0 = 1'b1; wr_en0 = w; addr0 = a; wr_data0 = d; wr_mask0 = 4'hF;
      @(negedge clk);
      checkOutput("b2b_stall", {31'b0, stall0}, 32'd1);
      checkOutput("b2b_no_ack", {31'b0, ack0}, 32'd0);
      @(negedge clk);
      e = sb.pop_front();
      checkOutput("b2b_ack", {31'b0, ack0}, 32'd1);
      checkOutput("b2b_rd_data", rd_data0, e.rd);
      checkOutput("b2b_err", {31'b0, err0}, {31'b0, e.err});
    end
    req0 = 1'b0;
    @(negedge clk);
    checkOutput("b2b_ack_drop", {31'b0, ack0}, 32'd0);
    checkOutput("b2b_idle", {31'b0, stall0}, 32'd0);

    // Reset during WAIT must abandon the store.
    applyStimulus(1'b1, 32'h1010, 32'h0000_0000, 4'b1111);
    req = 1'b1; wr_en = 1'b1; addr = 32'h1010; wr_data = 32'h0000_0055; wr_mask = 4'b0001;
    @(negedge clk);
    req = 1'b0;
    checkOutput("mid_stall", {31'b0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("mid_rst_ack", {31'b0, ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("mid_no_ack", {31'b0, ack}, 32'd0);
    end
    applyStimulus(1'b0, 32'h1010, 32'h0, 4'b0000);
    applyStimulus(1'b0, 32'h1004, 32'h0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
